elevator_request_ctrl: RTL

ELEVATOR_REQUEST_CTRL -- requirements
Module: elevator_request_ctrl

---
 rtl/elevator_request_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/elevator_request_ctrl.sv
// Elevator request controller: pending-floor register, door timer, Delay/FR_Delay
// handshakes with the car FSM and next-target selection.
module elevator_request_ctrl #(
  parameter int TICKS_PER_SEC = 100,
  parameter int OPEN_SECS     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] call_btn,
  input  logic [3:0] car_btn,
  input  logic       open_btn,
  input  logic       close_btn,
  input  logic       reset_clock,
  input  logic       Delay,
  input  logic       FR_Delay,
  input  logic [1:0] Actual_Stage,
  input  logic       UD_Answer,
  input  logic       STOP,
  output logic [3:0] actual_clock,
  output logic       DoneResetClock,
  output logic       DoneDelay,
  output logic       DoneFRDelay,
  output logic [2:0] next_stage,
  output logic       OC_Request,
  output logic       UD_Request,
  output logic       NO_STOP
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]    OPEN_LIM  = 4'(OPEN_SECS);

  typedef enum logic [2:0] {
    IDLE,
    DLY_SRV,
    DLY_ACK,
    FR_SRV,
    FR_ACK
  } hs_state_e;

  hs_state_e       state_q, state_d;
  logic [3:0]      pend_q, pend_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      clock_q, clock_d;
  logic [2:0]      next_q, next_d;
  logic            oc_q, oc_d;
  logic            ud_q, ud_d;
  logic            no_stop_q, no_stop_d;
  logic            done_rc_q, done_rc_d;
  logic            done_dly_q, done_dly_d;
  logic            done_fr_q, done_fr_d;
  logic            arrived_q, arrived_d;

  logic [3:0] pend_mix;
  logic [3:0] stage_hot;
  logic       recompute;
  logic [2:0] target;

  // Nearest pending floor in the preferred direction, falling back to the other
  // direction; the current floor itself is never a target.
  function automatic logic [2:0] pick_target(input logic [3:0] p, input logic [1:0] cur,
                                             input logic up);
    logic [2:0] above;
    logic [2:0] below;
    int         f;
    above = 3'b000;
    below = 3'b000;
    for (int d = 3; d >= 1; d--) begin
      f = int'(cur) + d;
      if (f <= 3 && p[f[1:0]]) above = {1'b1, f[1:0]};
      f = int'(cur) - d;
      if (f >= 0 && p[f[1:0]]) below = {1'b1, f[1:0]};
    end
    if (up) return above[2] ? above : below;
    else    return below[2] ? below : above;
  endfunction

  assign pend_mix  = pend_q | call_btn | car_btn;
  assign stage_hot = 4'b0001 << Actual_Stage;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_mix;
    presc_d    = presc_q;
    clock_d    = clock_q;
    next_d     = next_q;
    oc_d       = oc_q;
    ud_d       = ud_q;
    arrived_d  = arrived_q;
    recompute  = 1'b0;
    target     = 3'b000;

    if (reset_clock) begin
      presc_d = '0;
      clock_d = 4'd0;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      if (clock_q != 4'd15) clock_d = clock_q + 4'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // Door control outside the arrival-service cycle; open wins over close.
    if (open_btn && (STOP || state_q == DLY_ACK || (state_q == IDLE && arrived_q))) begin
      oc_d = 1'b1;
    end else if (close_btn || clock_q >= OPEN_LIM) begin
      oc_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (Delay)         state_d = DLY_SRV;
        else if (FR_Delay) state_d = FR_SRV;
      end
      DLY_SRV: begin
        state_d   = DLY_ACK;
        pend_d    = pend_mix & ~stage_hot;
        recompute = 1'b1;
        arrived_d = 1'b1;
        oc_d      = oc_q | pend_mix[Actual_Stage] | open_btn;
      end
      DLY_ACK: begin
        if (!Delay) state_d = IDLE;
      end
      FR_SRV: begin
        state_d   = FR_ACK;
        recompute = 1'b1;
        arrived_d = 1'b0;
      end
      FR_ACK: begin
        if (!FR_Delay) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (recompute) begin
      target = pick_target(pend_d, Actual_Stage, UD_Answer);
      next_d = target;
      if (target[2]) ud_d = (target[1:0] > Actual_Stage);
    end
  end

  assign no_stop_d  = |pend_q;
  assign done_rc_d  = reset_clock;
  assign done_dly_d = (state_d == DLY_ACK);
  assign done_fr_d  = (state_d == FR_ACK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= 4'b0000;
      presc_q    <= '0;
      clock_q    <= 4'd0;
      next_q     <= 3'b000;
      oc_q       <= 1'b0;
      ud_q       <= 1'b1;
      no_stop_q  <= 1'b0;
      done_rc_q  <= 1'b0;
      done_dly_q <= 1'b0;
      done_fr_q  <= 1'b0;
      arrived_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      presc_q    <= presc_d;
      clock_q    <= clock_d;
      next_q     <= next_d;
      oc_q       <= oc_d;
      ud_q       <= ud_d;
      no_stop_q  <= no_stop_d;
      done_rc_q  <= done_rc_d;
      done_dly_q <= done_dly_d;
      done_fr_q  <= done_fr_d;
      arrived_q  <= arrived_d;
    end
  end

  assign actual_clock   = clock_q;
  assign DoneResetClock = done_rc_q;
  assign DoneDelay      = done_dly_q;
  assign DoneFRDelay    = done_fr_q;
  assign next_stage     = next_q;
  assign OC_Request     = oc_q;
  assign UD_Request     = ud_q;
  assign NO_STOP        = no_stop_q;

endmodule
